// File: rtl/uart_pkg.sv
// Shared UART helpers used by both the transmit and receive blocks.
package uart_pkg;

    function automatic int uart_frame_bits(
        input int data_bits,
        input int parity_bits,
        input int stop_bits
    );
        return data_bits + parity_bits + stop_bits;
    endfunction

    function automatic logic uart_parity(input logic [9:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-word handshake bundle: word, status flags, valid/ready.
interface uart_rx_if #(
    parameter int DataBits = 8
);
    logic [DataBits-1:0] data_out;
    logic                data_out_valid;
    logic                data_out_ready;
    logic                parity_error;
    logic                frame_error;
    logic                overrun_error;

    modport master (
        output data_out, data_out_valid,
        output parity_error, frame_error, overrun_error,
        input  data_out_ready
    );

    modport slave (
        input  data_out, data_out_valid,
        input  parity_error, frame_error, overrun_error,
        output data_out_ready
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module sync_2ff #(
    parameter logic Reset = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= Reset;
            q  <= Reset;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of start/data/parity/stop bits.
module uart_rx
    import uart_pkg::*;
#(
    parameter int ClockDivider = 8,
    parameter int DataBits     = 8,
    parameter int StopBits     = 1,
    parameter int ParityBits   = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic in_bit,
    uart_rx_if.master rx
);
    localparam int Half = ClockDivider / 2;
    localparam int N =
        uart_frame_bits(DataBits, ParityBits, StopBits);
    localparam int CW = $clog2(ClockDivider);
    localparam int IW = $clog2(N);

    localparam logic [CW-1:0] CntHalf = CW'(Half - 1);
    localparam logic [CW-1:0] CntLast = CW'(ClockDivider - 1);
    localparam logic [IW-1:0] IdxData = IW'(DataBits - 1);
    localparam logic [IW-1:0] IdxLast = IW'(N - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    if (ClockDivider < 2 || DataBits < 5 || DataBits > 9 ||
        StopBits < 1 || StopBits > 2 ||
        ParityBits < 0 || ParityBits > 1) begin : g_bad_param
        $error("uart_rx: illegal parameter combination");
    end

    logic                in_sync;
    logic                in_prev;
    logic [2:0]          state;
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [DataBits-1:0] sh;
    logic                perr_acc;
    logic                ferr_acc;
    logic [DataBits-1:0] dout;
    logic                valid;
    logic                perr;
    logic                ferr;
    logic                ovr;
    logic                bit_end;

    sync_2ff #(.Reset(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (in_bit),
        .q   (in_sync)
    );

    assign bit_end = (cnt == CntLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            sh       <= '0;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
            in_prev  <= 1'b1;
            dout     <= '0;
            valid    <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            in_prev <= in_sync;
            ovr     <= 1'b0;
            cnt     <= cnt + 1'b1;
            if (valid && rx.data_out_ready)
                valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_prev && !in_sync) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    if (cnt == CntHalf) begin
                        cnt      <= '0;
                        idx      <= '0;
                        perr_acc <= 1'b0;
                        ferr_acc <= 1'b0;
                        state    <= in_sync ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        idx <= idx + 1'b1;
                        sh  <= {in_sync, sh[DataBits-1:1]};
                        if (idx == IdxData)
                            state <= (ParityBits != 0) ? S_PARITY
                                                       : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        cnt      <= '0;
                        idx      <= idx + 1'b1;
                        perr_acc <= uart_parity(10'({sh, in_sync}));
                        state    <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        idx <= idx + 1'b1;
                        if (idx != IdxLast) begin
                            ferr_acc <= ferr_acc | !in_sync;
                        end else begin
                            state <= S_IDLE;
                            // A held word still unread drops this one.
                            if (!valid || rx.data_out_ready) begin
                                dout  <= sh;
                                valid <= 1'b1;
                                perr  <= perr_acc;
                                ferr  <= ferr_acc | !in_sync;
                            end else begin
                                ovr <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign rx.data_out       = dout;
    assign rx.data_out_valid = valid;
    assign rx.parity_error   = perr;
    assign rx.frame_error    = ferr;
    assign rx.overrun_error  = ovr;
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver: the receive-side counterpart to the transmit block. It recovers frames from an asynchronous `in_bit` line and presents each received word on a valid/ready output with per-frame parity and framing status. Frame format and bit period match the transmitter: 1 start bit (0), `DataBits` data bits LSB first, optional even parity (`^data`), and `StopBits` stop bits (1). A transmitter instance with identical parameters loops back cleanly into this block.

## Interface
- `ClockDivider`, 8: clk cycles per bit; legal range ≥ 2.
- `DataBits`, 8: data bits per frame; legal range [5,9].
- `StopBits`, 1: stop bits; 1 or 2.
- `ParityBits`, 0: 0 = no parity, 1 = even parity bit after data.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_bit`  in  1  serial line; asynchronous to `clk`; idle high.
- `data_out`  out  DataBits  received word.
- `data_out_valid`  out  1  `data_out` and status flags are valid.
- `data_out_ready`  in  1  consumer accepts; transfer occurs when valid && ready.
- `parity_error`  out  1  parity mismatch on the held word; 0 when `ParityBits`=0.
- `frame_error`  out  1  at least one stop bit sampled 0 on the held word.
- `overrun_error`  out  1  one-cycle pulse: a frame was dropped.

## Operation
- Illegal parameters trigger `$error` at elaboration.
- `in_bit` passes through a 2-flop synchronizer to produce `in_sync`; both flops reset to 1.
- `Half` = `ClockDivider`/2 (floor). The bit counter is $clog2(ClockDivider) wide and the bit index is $clog2(DataBits+ParityBits+StopBits) wide.
- State machine (IDLE, START, DATA, PARITY, STOP):
  - IDLE: a 1→0 edge on `in_sync` → START, counter cleared. A line held low never triggers.
  - START: when counter = Half−1, sample. If 0 → DATA, counter cleared. If 1 → IDLE (glitch rejected, nothing reported).
  - DATA: sample when counter = ClockDivider−1; shift sample into the MSB (LSB-first reconstruction). After `DataBits` samples → PARITY if `ParityBits`, else STOP.
  - PARITY: one sample; error = `^{data, p}` ≠ 0.
  - STOP: `StopBits` samples; any 0 sets `frame_error`. After the last sample → IDLE the same cycle, and the frame completes.
- Frame completion:
  - If `data_out_valid` is 0, or valid && ready in the same cycle: load `data_out`, `parity_error`, `frame_error`, and assert valid.
  - Otherwise: keep the old word and flags, drop the new frame, and pulse `overrun_error`.
- A frame with errors is still delivered, with its flags set.
- Valid deasserts the cycle after a transfer, unless a completion coincides with that transfer.
- `rst` mid-frame: returns to IDLE and discards the partial frame.

## Timing
- Reset values:
  - `data_out` = 0, `data_out_valid` = 0, all error outputs = 0.
  - State = IDLE, synchronizer = 1.
- `in_bit` → `in_sync`: 2 cycles.
- Let E be the cycle `in_sync` first reads 0.
  - Start sample: E+Half.
  - Bit k sample (k = 0 first data bit, through stop bits): E+Half+(k+1)·ClockDivider.
- Let N = DataBits+ParityBits+StopBits. `data_out_valid` rises at E+Half+N·ClockDivider+1.
- Back-to-back frames: after the last stop sample, the next start edge is accepted from the following cycle.
- `overrun_error` is high for exactly one cycle, aligned with the dropped frame's completion cycle.

## Structure
- `uart_pkg`: `uart_frame_bits(DataBits, ParityBits, StopBits)` function and `uart_parity` function, shared with the transmitter.
- State enum stays local.
- Sub-module: `sync_2ff` (2-flop synchronizer with reset value parameter). The shift register stays inline.

## Test plan
- 8N1, ClockDivider=8, send 0xA5 → `data_out`=0xA5, valid rises at E+77, no errors; ready=1 → valid falls next cycle.
- 2-cycle low glitch on idle line → state returns to IDLE at E+4; no valid, no errors. Repeat with `rst` asserted mid-frame (bit 3): no valid; next frame 0x3C received correctly.
- ParityBits=1, send 0x01 with parity bit 0 → `data_out`=0x01, `parity_error`=1. Resend with parity bit 1 → `parity_error`=0.
- StopBits=2, second stop bit driven 0 → `frame_error`=1, data intact. Hold line low afterward → no further frames.
- Send 0x12 then 0x34 back-to-back with ready=0 → `overrun_error` pulses once, `data_out` stays 0x12. Assert ready on the cycle 0x56 completes → 0x56 loads, valid stays high, no overrun.
- Loopback with the transmitter, all parameter combos, 1000 random words, ready randomly toggled but never overrunning → every word matches in order, no errors.
